barrel_shifter_pipe: RTL and testbench
======================================

BARREL_SHIFTER_PIPE -- requirements
Module: barrel_shifter_pipe

Interface
REQ-001 Parameter WIDTH, default 32, sets the data width in bits; it SHALL be a power of two, 2 or greater.
REQ-002 Derived localparam SA_W = log2(WIDTH), default 5, sets the shift-amount width and the pipeline stage count.
REQ-003 Port i_clk, input, 1 bit, SHALL be the single clock; all state changes on its rising edge.
REQ-004 Port i_rst_n, input, 1 bit, SHALL be the asynchronous active-low reset.
REQ-005 Port i_valid, input, 1 bit, SHALL mark the input word as valid.
REQ-006 Port o_ready, output, 1 bit, SHALL signal that the block can accept input this cycle.
REQ-007 Port i_data, input, WIDTH bits, SHALL carry the operand.
REQ-008 Port i_sa, input, SA_W bits, SHALL carry the shift amount, 0..WIDTH-1.
REQ-009 Port i_dir, input, 1 bit, SHALL select direction: 0 = right, 1 = left.
REQ-010 Port i_st, input, 2 bits, SHALL select shift type: 00 = logical, 01 = arithmetic, 10 = rotate, 11 = reserved.
REQ-011 Port o_valid, output, 1 bit, SHALL mark o_data as valid.
REQ-012 Port i_ready, input, 1 bit, SHALL signal that downstream accepts o_data.
REQ-013 Port o_data, output, WIDTH bits, SHALL carry the shifted result.

Function
REQ-014 Handshake: a transfer SHALL occur on a clock edge where valid and ready are both high. Input side: i_valid with o_ready. Output side: o_valid with i_ready.
REQ-015 The datapath SHALL be SA_W cascaded stages. Stage k conditionally shifts by 2^k under control of i_sa[k]. Each stage SHALL have its own output register, valid bit, and captured copies of the unused i_sa bits, i_dir and i_st.
REQ-016 Latency SHALL be exactly SA_W cycles from input transfer to o_valid, with i_ready held high. Throughput SHALL be one word per cycle.
REQ-017 Stage k SHALL load when its own valid is low or when stage k+1 loads; the last stage loads when its valid is low or i_ready is high. This rule means no bubbles are inserted and no data is lost.
REQ-018 o_ready SHALL equal the stage-0 load condition and SHALL have no combinational path from i_valid.
REQ-019 While o_valid is high and i_ready is low, o_data and o_valid SHALL hold stable.
REQ-020 Right logical: vacated MSBs SHALL be filled with 0.
REQ-021 Right arithmetic: vacated MSBs SHALL be filled with the operand's original bit WIDTH-1.
REQ-022 Left logical and left arithmetic: vacated LSBs SHALL be filled with 0; the two types SHALL give identical results.
REQ-023 Rotate: bits shifted out SHALL re-enter at the opposite end, in the direction set by i_dir.
REQ-024 i_st = 11 SHALL behave as logical.
REQ-025 i_sa = 0 SHALL pass i_data unchanged for every type and direction, at the full latency.
REQ-026 The stages SHALL use no shared state, so concurrent words in different stages SHALL NOT affect one another.

Reset
REQ-027 While i_rst_n is low, all stage valids and o_valid SHALL be 0, o_data and all stage registers SHALL be 0, and o_ready SHALL be 0.
REQ-028 Reset asserted mid-operation SHALL discard all in-flight words immediately; no stale word SHALL appear after release.
REQ-029 o_ready SHALL go high on the first clock edge after i_rst_n deasserts.

Configuration
REQ-030 Macro BARREL_SHIFTER_PIPE_ROTATE_EN defined: rotate (i_st = 10) SHALL be implemented as in REQ-023.
REQ-031 Macro BARREL_SHIFTER_PIPE_ROTATE_EN undefined: rotate logic SHALL be omitted, and i_st = 10 SHALL behave as logical.

Verification (WIDTH = 8, SA_W = 3)
REQ-032 Input 0x96, i_sa = 3, right logical, i_ready = 1 -> o_data 0x12 with o_valid high, 3 cycles after input transfer.
REQ-033 Input 0x96, i_sa = 3, right arithmetic -> 0xF2. Same input, left arithmetic -> 0xB0. Same input, i_sa = 0 -> 0x96.
REQ-034 Input 0x96, i_sa = 3, right rotate -> 0xD2 with BARREL_SHIFTER_PIPE_ROTATE_EN defined, and 0x12 without it. Same input, left rotate -> 0xB4 with the macro defined.
REQ-035 Throughput: 8 back-to-back words 0x01..0x08 with i_sa = 1, left logical, i_ready = 1 -> 0x02..0x10 on 8 consecutive cycles starting at cycle 3.
REQ-036 Backpressure: stream 6 words and hold i_ready low for 5 cycles from the first o_valid -> o_data stable during the stall, o_ready low once all 3 stages are full, all 6 results delivered in order with none duplicated after i_ready returns high.
REQ-037 Reset mid-stream: pull i_rst_n low with 3 words in flight -> o_valid drops at once and stays 0, and no pre-reset word is output after release.

Source files
------------

// File: rtl/barrel_shifter_pipe.sv
// Pipelined barrel shifter: SA_W = log2(WIDTH) cascaded stages, stage k shifting by 2^k
// when shift-amount bit k is set. Valid/ready handshake on both sides, one word per cycle,
// with no bubbles under backpressure.
// Optional feature: define BARREL_SHIFTER_PIPE_ROTATE_EN to implement rotate (st = 2'b10);
// without it, rotate requests behave as logical shifts.
module barrel_shifter_pipe #(
  parameter int unsigned WIDTH = 32,
  localparam int unsigned SA_W = $clog2(WIDTH)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  input  logic [SA_W-1:0]  i_sa,
  input  logic             i_dir,
  input  logic [1:0]       i_st,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data
);

  localparam logic [1:0] StArith = 2'b01;
`ifdef BARREL_SHIFTER_PIPE_ROTATE_EN
  localparam logic [1:0] StRotate = 2'b10;
`endif

  // Stage registers; index k holds the output of stage k.
  logic [SA_W-1:0][WIDTH-1:0] data_q;
  logic [SA_W-1:0][SA_W-1:0]  sa_q;
  logic [SA_W-1:0]            dir_q;
  logic [SA_W-1:0][1:0]       st_q;
  logic [SA_W-1:0]            valid_q;

  // Stage inputs; index 0 is the block input, index k+1 is the output of stage k.
  logic [SA_W:0][WIDTH-1:0] data_s;
  logic [SA_W:0][SA_W-1:0]  sa_s;
  logic [SA_W:0]            dir_s;
  logic [SA_W:0][1:0]       st_s;
  logic [SA_W:0]            valid_s;

  logic [SA_W-1:0][WIDTH-1:0] shift_res;
  logic [SA_W:0]              load;  // load[SA_W] is the downstream ready
  logic                       run_q;
  logic                       accept;
  logic                       unused_ctrl;

  assign accept  = i_valid & o_ready;
  assign data_s  = {data_q, i_data};
  assign sa_s    = {sa_q, i_sa};
  assign dir_s   = {dir_q, i_dir};
  assign st_s    = {st_q, i_st};
  assign valid_s = {valid_q, accept};

  // The last stage's control copies and the already-consumed shift bits are not needed.
  assign unused_ctrl = ^{sa_s, dir_s[SA_W], st_s[SA_W]};

  // Load chain: a stage loads when empty or when the stage after it moves on.
  always_comb begin
    load[SA_W] = i_ready;
    for (int k = int'(SA_W) - 1; k >= 0; k--) begin
      load[k] = ~valid_q[k] | load[k+1];
    end
  end

  // Input side stays closed until the first clock edge after reset release.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      run_q <= 1'b0;
    end else begin
      run_q <= 1'b1;
    end
  end

  assign o_ready = run_q & load[0];

  for (genvar k = 0; k < SA_W; k++) begin : g_stage
    localparam int unsigned Amt = 2 ** k;
    logic [WIDTH-1:0] res;

    // Shift by 2^k when this stage's shift-amount bit is set.
    always_comb begin
      res = data_s[k];
      if (sa_s[k][k]) begin
        if (dir_s[k]) begin
          res = data_s[k] << Amt;
`ifdef BARREL_SHIFTER_PIPE_ROTATE_EN
          if (st_s[k] == StRotate) begin
            res = res | (data_s[k] >> (WIDTH - Amt));
          end
`endif
        end else begin
          res = data_s[k] >> Amt;
          // Right shifts preserve the MSB, so it still equals the operand's original sign.
          if (st_s[k] == StArith) begin
            res = res | ({WIDTH{data_s[k][WIDTH-1]}} << (WIDTH - Amt));
          end
`ifdef BARREL_SHIFTER_PIPE_ROTATE_EN
          if (st_s[k] == StRotate) begin
            res = res | (data_s[k] << (WIDTH - Amt));
          end
`endif
        end
      end
    end

    assign shift_res[k] = res;
  end

  // Stage registers advance independently under their own load condition.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      data_q  <= '0;
      sa_q    <= '0;
      dir_q   <= '0;
      st_q    <= '0;
      valid_q <= '0;
    end else begin
      for (int k = 0; k < int'(SA_W); k++) begin
        if (load[k]) begin
          data_q[k]  <= shift_res[k];
          sa_q[k]    <= sa_s[k];
          dir_q[k]   <= dir_s[k];
          st_q[k]    <= st_s[k];
          valid_q[k] <= valid_s[k];
        end
      end
    end
  end

  assign o_valid = valid_s[SA_W];
  assign o_data  = data_s[SA_W];

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// Self-checking bench for barrel_shifter_pipe at WIDTH = 8.
`timescale 1ns/1ps
module tb_barrel_shifter_pipe;

`ifdef BARREL_SHIFTER_PIPE_ROTATE_EN
  localparam bit RotEn = 1'b1;
`else
  localparam bit RotEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_valid = 1'b0;
  logic       o_ready;
  logic [7:0] i_data = 8'h00;
  logic [2:0] sa = 3'd0;
  logic       dir = 1'b0;
  logic [1:0] st = 2'b00;
  logic       o_valid;
  logic       i_ready = 1'b1;
  logic [7:0] o_data;

  int checks = 0;
  int passed = 0;
  int delivered = 0;
  logic [7:0] exp_q[$];
  bit hold_prev = 1'b0;
  logic [7:0] held = 8'h00;

  always #5 clk = ~clk;

  barrel_shifter_pipe #(.WIDTH(8)) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .i_valid(i_valid),
    .o_ready(o_ready),
    .i_data (i_data),
    .i_sa   (sa),
    .i_dir  (dir),
    .i_st   (st),
    .o_valid(o_valid),
    .i_ready(i_ready),
    .o_data (o_data)
  );

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endfunction

  // Bit-by-bit reference: each result bit picks its source bit or a fill value.
  function automatic logic [7:0] model(logic [7:0] d, int s, bit left, logic [1:0] t);
    logic [7:0] r;
    int src;
    for (int i = 0; i < 8; i++) begin
      src = left ? i - s : i + s;
      if (src >= 0 && src < 8) r[i] = d[src];
      else if (t == 2'b10 && RotEn) r[i] = d[(src + 8) % 8];
      else if (!left && t == 2'b01) r[i] = d[7];
      else r[i] = 1'b0;
    end
    return r;
  endfunction

  // Scoreboard: push on input transfer, pop on output transfer, check stall stability.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        chk("stall_valid", o_valid, 1);
        chk("stall_data", o_data, held);
      end
      if (o_valid && i_ready) begin
        if (exp_q.size() == 0) chk("unexpected_output", o_valid, 0);
        else begin
          chk("model_data", o_data, exp_q.pop_front());
          delivered++;
        end
      end
      if (i_valid && o_ready) exp_q.push_back(model(i_data, int'(sa), dir, st));
      hold_prev = o_valid && !i_ready;
      held = o_data;
    end
  end

  task automatic single(string name, logic [7:0] d, logic [2:0] s, logic dr, logic [1:0] t,
                        logic [7:0] exp);
    int n;
    bit seen;
    i_data = d; sa = s; dir = dr; st = t; i_valid = 1'b1; i_ready = 1'b1;
    #1 chk({name, "_ready"}, o_ready, 1);
    n = 0;
    seen = 1'b0;
    while (!seen && n < 10) begin
      @(posedge clk); #1;
      n++;
      i_valid = 1'b0;
      if (o_valid) seen = 1'b1;
    end
    chk({name, "_latency"}, n, 3);
    chk({name, "_data"}, o_data, exp);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int first, cnt, w, stall, base, iter, idx;
    bit saw_nr, acc;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", o_valid, 0);
    chk("rst_ready", o_ready, 0);
    chk("rst_data", o_data, 0);
    #2 rst_n = 1'b1;
    #1 chk("ready_before_edge", o_ready, 0);
    @(posedge clk); #1;
    chk("ready_after_reset", o_ready, 1);

    // Directed single words with hand-computed results
    single("rlog", 8'h96, 3'd3, 1'b0, 2'b00, 8'h12);
    single("rari", 8'h96, 3'd3, 1'b0, 2'b01, 8'hF2);
    single("lari", 8'h96, 3'd3, 1'b1, 2'b01, 8'hB0);
    single("llog", 8'h96, 3'd3, 1'b1, 2'b00, 8'hB0);
    single("sa0r", 8'h96, 3'd0, 1'b0, 2'b01, 8'h96);
    single("sa0l", 8'h96, 3'd0, 1'b1, 2'b10, 8'h96);
    single("rres", 8'h96, 3'd3, 1'b0, 2'b11, 8'h12);
    single("rrot", 8'h96, 3'd3, 1'b0, 2'b10, RotEn ? 8'hD2 : 8'h12);
    single("lrot", 8'h96, 3'd3, 1'b1, 2'b10, RotEn ? 8'hB4 : 8'hB0);
    single("ari7", 8'h81, 3'd7, 1'b0, 2'b01, 8'hFF);
    single("lrt1", 8'h81, 3'd1, 1'b1, 2'b10, RotEn ? 8'h03 : 8'h02);

    // Throughput: 8 back-to-back words, left logical by 1
    first = -1;
    cnt = 0;
    for (int n = 0; n < 12; n++) begin
      if (n < 8) begin
        i_valid = 1'b1; i_data = 8'(n + 1); sa = 3'd1; dir = 1'b1; st = 2'b00;
      end else i_valid = 1'b0;
      #1;
      if (n < 8) chk("tp_ready", o_ready, 1);
      @(posedge clk); #1;
      if (o_valid) begin
        if (first < 0) first = n;
        chk("tp_data", o_data, 8'((cnt + 1) * 2));
        chk("tp_slot", n, first + cnt);
        cnt++;
      end
    end
    chk("tp_first", first, 2);
    chk("tp_count", cnt, 8);

    // Backpressure: 6 words, downstream stalls 5 cycles from first o_valid
    w = 0; stall = -1; base = delivered; iter = 0; saw_nr = 1'b0;
    while ((w < 6 || exp_q.size() > 0) && iter < 60) begin
      if (stall < 0 && o_valid) stall = 5;
      i_ready = !(stall > 0);
      if (stall > 0) stall--;
      if (w < 6) begin
        i_valid = 1'b1; i_data = 8'(8'hA5 + 8'(w * 7)); sa = 3'(w + 1);
        dir = w[0]; st = 2'(w % 3);
      end else i_valid = 1'b0;
      #1;
      if (!o_ready) saw_nr = 1'b1;
      acc = i_valid && o_ready;
      @(posedge clk); #1;
      if (acc) w++;
      iter++;
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    chk("bp_sent", w, 6);
    chk("bp_ready_low", saw_nr, 1);
    chk("bp_delivered", delivered - base, 6);
    chk("bp_drained", exp_q.size(), 0);

    // Sweep every shift amount, direction and type with an irregular ready pattern
    idx = 0; iter = 0;
    while (idx < 64 && iter < 400) begin
      i_ready = (iter % 3) != 2;
      i_valid = 1'b1; i_data = 8'(idx * 37 + 11); sa = 3'(idx % 8);
      dir = idx[3]; st = 2'(idx / 16);
      #1;
      acc = o_ready;
      @(posedge clk); #1;
      if (acc) idx++;
      iter++;
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    iter = 0;
    while (exp_q.size() > 0 && iter < 20) begin
      @(posedge clk); #1;
      iter++;
    end
    chk("sweep_sent", idx, 64);
    chk("sweep_drained", exp_q.size(), 0);

    // Reset mid-stream with 3 words in flight
    for (int n = 0; n < 3; n++) begin
      i_valid = 1'b1; i_data = 8'(8'h11 * (n + 1)); sa = 3'd1; dir = 1'b0; st = 2'b00;
      @(posedge clk); #1;
    end
    i_valid = 1'b0;
    chk("mid_inflight_valid", o_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_valid_drop", o_valid, 0);
    chk("mid_ready_drop", o_ready, 0);
    chk("mid_data_clear", o_data, 0);
    repeat (2) @(posedge clk);
    #1 chk("mid_valid_held", o_valid, 0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("mid_ready_after", o_ready, 1);
    for (int n = 0; n < 6; n++) begin
      chk("mid_no_stale", o_valid, 0);
      @(posedge clk); #1;
    end
    chk("final_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
